// File: rtl/steer_pkg.sv
// Shared definitions for the swerve steering sequencer: sizes, move tolerance,
// FSM state encoding and the unsigned angle distance helper.
package steer_pkg;

  localparam int NUM_WHEELS = 4;
  localparam int ANGLE_W    = 12;

  localparam logic [ANGLE_W:0] TOLERANCE = 13'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_SETTLE,
    ST_WAIT,
    ST_DONE,
    ST_ABORT
  } state_e;

  // Straight magnitude of the difference; 4095 and 0 are far apart, not neighbours.
  function automatic logic [ANGLE_W:0] abs_diff(input logic [ANGLE_W-1:0] a,
                                                input logic [ANGLE_W-1:0] b);
    logic [ANGLE_W:0] ea;
    logic [ANGLE_W:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick among four requesters, starting the search
// at the pointer and wrapping past wheel 3 back to wheel 0.
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_idx_o,
  output logic       any_req_o
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_req_o = |req_i;
    idx       = '0;
    found     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_i + 2'(i);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_idx_o  = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/steer_sequencer.sv
// Time-shares one angle_to_pwm engine among the swerve wheels: latches per-wheel
// targets, grants pending wheels round-robin, launches the engine and supervises it.
module steer_sequencer
  import steer_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
  parameter int unsigned SETTLE_CYCLES  = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic [1:0]                    cmd_wheel,
  input  logic [ANGLE_W-1:0]            cmd_angle,
  input  logic [NUM_WHEELS*ANGLE_W-1:0] enc_angle,
  input  logic                          angle_done,
  input  logic                          err_clear,
  output logic [ANGLE_W-1:0]            target_angle,
  output logic [ANGLE_W-1:0]            current_angle,
  output logic                          angle_update,
  output logic                          engine_rst_n,
  output logic [1:0]                    sel_wheel,
  output logic                          busy,
  output logic                          done_pulse,
  output logic [1:0]                    done_wheel,
  output logic [NUM_WHEELS-1:0]         err_timeout
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);

  state_e                  state_q, state_d;
  logic [NUM_WHEELS-1:0]   pending_q, pending_d;
  logic [ANGLE_W-1:0]      targets_q [NUM_WHEELS];
  logic [ANGLE_W-1:0]      target_q, target_d;
  logic [1:0]              sel_q, sel_d;
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic [7:0]              settle_cnt_q, settle_cnt_d;
  logic [23:0]             tmo_cnt_q, tmo_cnt_d;
  logic                    abort_cnt_q, abort_cnt_d;
  logic                    update_q, update_d;
  logic [NUM_WHEELS-1:0]   err_q, err_d;

  logic [3:0]              gnt;
  logic [1:0]              gnt_idx;
  logic                    any_req;
  logic [ANGLE_W:0]        delta;

  rr_arbiter4 u_arb (
    .req_i     (pending_q),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_req_o (any_req)
  );

  // The select is registered, so the engine sees a glitch-free encoder slice.
  always_comb begin
    current_angle = enc_angle[ANGLE_W*sel_q +: ANGLE_W];
  end

  assign delta = abs_diff(target_q, current_angle);

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    target_d     = target_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr_q;
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    abort_cnt_d  = abort_cnt_q;
    update_d     = 1'b0;
    err_d        = err_clear ? '0 : err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (any_req) begin
          sel_d        = gnt_idx;
          target_d     = targets_q[gnt_idx];
          pending_d    = pending_q & ~gnt;
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          if (delta <= TOLERANCE) begin
            state_d = ST_DONE;
          end else begin
            update_d  = 1'b1;
            tmo_cnt_d = '0;
            state_d   = ST_WAIT;
          end
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      ST_WAIT: begin
        // A completion arriving on the expiry cycle still counts as success.
        if (angle_done) begin
          state_d = ST_DONE;
        end else if (tmo_cnt_q == TIMEOUT_CYCLES - 24'd1) begin
          err_d[sel_q] = 1'b1;
          abort_cnt_d  = 1'b0;
          state_d      = ST_ABORT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 24'd1;
        end
      end
      ST_ABORT: begin
        if (abort_cnt_q) state_d = ST_IDLE;
        else             abort_cnt_d = 1'b1;
      end
      ST_DONE: begin
        rr_ptr_d = sel_q + 2'd1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh command re-pends its wheel even if it was just granted.
    if (cmd_valid) pending_d[cmd_wheel] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      target_q     <= '0;
      sel_q        <= '0;
      rr_ptr_q     <= '0;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      abort_cnt_q  <= 1'b0;
      update_q     <= 1'b0;
      err_q        <= '0;
      for (int i = 0; i < NUM_WHEELS; i++) targets_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      target_q     <= target_d;
      sel_q        <= sel_d;
      rr_ptr_q     <= rr_ptr_d;
      settle_cnt_q <= settle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      abort_cnt_q  <= abort_cnt_d;
      update_q     <= update_d;
      err_q        <= err_d;
      if (cmd_valid) targets_q[cmd_wheel] <= cmd_angle;
    end
  end

  assign target_angle = target_q;
  assign angle_update = update_q;
  assign engine_rst_n = (state_q != ST_ABORT);
  assign sel_wheel    = sel_q;
  assign busy         = (state_q != ST_IDLE);
  assign done_pulse   = (state_q == ST_DONE);
  assign done_wheel   = sel_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_steer_sequencer.sv
// Self-checking bench for steer_sequencer: directed scenarios plus randomized
// command batches, predicted by a transaction-level round-robin model.
module tb_steer_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_wheel;
  logic [11:0] cmd_angle;
  logic [47:0] enc_angle;
  logic        angle_done;
  logic        err_clear;
  logic [11:0] target_angle;
  logic [11:0] current_angle;
  logic        angle_update;
  logic        engine_rst_n;
  logic [1:0]  sel_wheel;
  logic        busy;
  logic        done_pulse;
  logic [1:0]  done_wheel;
  logic [3:0]  err_timeout;

  localparam int TMO    = 100;
  localparam int SETTLE = 2;

  always #5 clock = ~clock;

  steer_sequencer #(.TIMEOUT_CYCLES(24'd100), .SETTLE_CYCLES(SETTLE)) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_wheel     (cmd_wheel),
    .cmd_angle     (cmd_angle),
    .enc_angle     (enc_angle),
    .angle_done    (angle_done),
    .err_clear     (err_clear),
    .target_angle  (target_angle),
    .current_angle (current_angle),
    .angle_update  (angle_update),
    .engine_rst_n  (engine_rst_n),
    .sel_wheel     (sel_wheel),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .done_wheel    (done_wheel),
    .err_timeout   (err_timeout)
  );

  typedef struct {
    int w;
    int a;
  } cmd_t;

  // Reference model: what the host has asked for, not how the FSM does it.
  bit         pend [4];
  int         tgt  [4];
  int         enc  [4];
  int         ptr;
  logic [3:0] errs;
  cmd_t       extraQ [$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int predictGrant();
    for (int i = 0; i < 4; i++) begin
      if (pend[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return 0;
  endfunction

  function automatic bit anyPend();
    return pend[0] | pend[1] | pend[2] | pend[3];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0;
      tgt[i]  = 0;
    end
    ptr  = 0;
    errs = '0;
    extraQ.delete();
  endtask

  task automatic setEnc(input int w, input int a);
    enc[w] = a;
    enc_angle[12*w +: 12] = 12'(a);
  endtask

  task automatic applyStimulus(input int w, input int a);
    cmd_valid = 1'b1;
    cmd_wheel = 2'(w);
    cmd_angle = 12'(a);
    tgt[w]    = a;
    pend[w]   = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_sel"},       sel_wheel, 0);
    check({tag, "_update"},    angle_update, 0);
    check({tag, "_rst_n"},     engine_rst_n, 1);
    check({tag, "_done"},      done_pulse, 0);
    check({tag, "_done_w"},    done_wheel, 0);
    check({tag, "_err"},       err_timeout, 0);
    check({tag, "_target"},    target_angle, 0);
  endtask

  // Serve the next predicted wheel; mode 0 answers with angle_done, mode 1 lets it time out.
  task automatic checkOutput(input int mode);
    int   g, eTgt, n, updCyc;
    bit   launch, sawDone;
    cmd_t c;
    g       = predictGrant();
    pend[g] = 1'b0;
    eTgt    = tgt[g];
    launch  = absd(tgt[g], enc[g]) > 2;
    n = 0;
    while (!(angle_update || done_pulse) && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("event_seen", angle_update || done_pulse, 1);
    check("latency", n, 3 + SETTLE);
    check("sel_wheel", sel_wheel, g);
    check("target_angle", target_angle, eTgt);
    check("current_angle", current_angle, enc[g]);
    check("launch", angle_update, launch);
    if (!launch) begin
      check("skip_done", done_pulse, 1);
      check("skip_done_wheel", done_wheel, g);
      ptr = (g + 1) % 4;
      @(negedge clock);
      check("skip_done_one_cycle", done_pulse, 0);
      return;
    end
    updCyc = cyc;
    @(negedge clock);
    check("update_one_cycle", angle_update, 0);
    while (extraQ.size() > 0) begin
      c = extraQ.pop_front();
      applyStimulus(c.w, c.a);
    end
    if (mode == 0) begin
      repeat ($urandom_range(0, 4)) @(negedge clock);
      check("busy_in_wait", busy, 1);
      angle_done = 1'b1;
      @(negedge clock);
      angle_done = 1'b0;
      n = 0;
      while (!done_pulse && n < 10) begin
        @(negedge clock);
        n++;
      end
      check("done_pulse", done_pulse, 1);
      check("done_wheel", done_wheel, g);
      check("done_sel_held", sel_wheel, g);
      check("done_target_held", target_angle, eTgt);
      check("done_rst_n", engine_rst_n, 1);
      ptr = (g + 1) % 4;
      @(negedge clock);
      check("done_one_cycle", done_pulse, 0);
    end else begin
      n = 0;
      sawDone = 1'b0;
      while (engine_rst_n && n < 300) begin
        if (done_pulse) sawDone = 1'b1;
        @(negedge clock);
        n++;
      end
      check("abort_cycles", cyc - updCyc, TMO);
      errs[g] = 1'b1;
      check("err_timeout", err_timeout, errs);
      check("abort_no_done", done_pulse | sawDone, 0);
      @(negedge clock);
      check("rst_n_low_2nd", engine_rst_n, 0);
      @(negedge clock);
      check("rst_n_release", engine_rst_n, 1);
      check("abort_no_done_after", done_pulse, 0);
      check("abort_idle", busy, 0);
    end
  endtask

  initial begin
    int   w0, nx, w, a, n;
    cmd_t c;
    bit   leftIdle;

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_wheel  = '0;
    cmd_angle  = '0;
    enc_angle  = '0;
    angle_done = 1'b0;
    err_clear  = 1'b0;
    modelReset();
    for (int i = 0; i < 4; i++) setEnc(i, 0);
    #1;
    checkReset("por");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Single launched move on wheel 2.
    setEnc(2, 100);
    applyStimulus(2, 300);
    checkOutput(0);

    // Skip: wheel 1 already within tolerance.
    setEnc(1, 501);
    applyStimulus(1, 500);
    checkOutput(0);

    // Round robin: 0,1,3 then a late command for 0 served after 3.
    for (int i = 0; i < 4; i++) setEnc(i, 100);
    applyStimulus(0, 2000);
    extraQ.push_back('{w: 1, a: 2100});
    extraQ.push_back('{w: 3, a: 2200});
    checkOutput(0);
    extraQ.push_back('{w: 0, a: 1500});
    checkOutput(0);
    check("rr_order_3", predictGrant(), 3);
    checkOutput(0);
    checkOutput(0);

    // Re-command during own WAIT.
    applyStimulus(0, 3000);
    extraQ.push_back('{w: 0, a: 900});
    checkOutput(0);
    checkOutput(0);

    // Timeout then sticky flag clear.
    applyStimulus(2, 3500);
    checkOutput(1);
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    errs = '0;
    check("err_cleared", err_timeout, 0);

    // No modular wrap; tolerance edge.
    setEnc(3, 4095);
    applyStimulus(3, 0);
    checkOutput(0);
    setEnc(3, 0);
    applyStimulus(3, 2);
    checkOutput(0);
    applyStimulus(3, 3);
    checkOutput(0);

    // angle_done while idle does nothing.
    angle_done = 1'b1;
    @(negedge clock);
    angle_done = 1'b0;
    check("stray_done_busy", busy, 0);
    check("stray_done_pulse", done_pulse, 0);

    // Randomized batches.
    for (int it = 0; it < 15; it++) begin
      for (int i = 0; i < 4; i++) setEnc(i, int'($urandom_range(0, 4095)));
      w0 = int'($urandom_range(0, 3));
      applyStimulus(w0, (enc[w0] + 2048) % 4096);
      nx = int'($urandom_range(0, 4));
      for (int k = 0; k < nx; k++) begin
        w = int'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) begin
          a = enc[w] + int'($urandom_range(0, 6)) - 3;
          if (a < 0) a = 0;
          if (a > 4095) a = 4095;
        end else begin
          a = int'($urandom_range(0, 4095));
        end
        c.w = w;
        c.a = a;
        extraQ.push_back(c);
      end
      checkOutput(($urandom_range(0, 7) == 0) ? 1 : 0);
      n = 0;
      while (anyPend() && n < 8) begin
        checkOutput(($urandom_range(0, 9) == 0) ? 1 : 0);
        n++;
      end
    end

    // Reset in the middle of a WAIT with another wheel pending.
    setEnc(1, 10);
    applyStimulus(1, 3000);
    n = 0;
    while (!angle_update && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("pre_reset_update", angle_update, 1);
    applyStimulus(2, 1234);
    #2;
    reset = 1'b1;
    #1;
    checkReset("mid_wait");
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    leftIdle = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (busy) leftIdle = 1'b1;
    end
    check("pending_dropped", leftIdle, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
